hex_scan_595: RTL and testbench

Parametrised successor to the fixed 8-digit scan and 74HC595 serialiser pair. A single block scans DIGITS hex digits, decodes them, and serialises one 16-bit frame per digit into a 74HC595 chain. Over the fixed pair it adds per-digit decimal points, leading-zero blanking, selectable segment/select polarity, and a valid/ready load port that only updates the display at frame boundaries, so the display never tears.

---
 rtl/hex_scan_595.sv | 204 ++++++++++++++++++++
 tb/tb_hex_scan_595.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_595.sv
// Multiplexed hex display driver: scans DIGITS nibbles, decodes them to 7-segment
// patterns and serialises one 16-bit {dp, seg g..a, sel} frame per digit into a 74HC595 chain.
module hex_scan_595 #(
    parameter int unsigned DIGITS         = 8,
    parameter int unsigned SHIFT_DIV      = 2,
    parameter int unsigned SCAN_CYCLES    = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  disp_en,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic                  ds,
    output logic                  sh_cp,
    output logic                  st_cp,
    output logic                  frame_done
);

    localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int unsigned CW = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
    localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(SHIFT_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

    logic [SW-1:0]         scan_q;
    logic [DW-1:0]         digit_q;
    logic [4*DIGITS-1:0]   data_q, pdata_q;
    logic [DIGITS-1:0]     dp_q, pdp_q;
    logic                  blz_q, pblz_q;
    logic                  ready_q;

    state_t                state_q;
    logic [15:0]           sreg_q;
    logic [CW-1:0]         div_q;
    logic [3:0]            bit_q;
    logic                  ds_q, sh_q, st_q, fd_q;

    logic                  scan_wrap, frame_wrap;
    logic [3:0]            nib;
    logic                  upper_nz;
    logic                  blank;
    logic [6:0]            seg_on;
    logic                  dp_on;
    logic [7:0]            sel_on;
    logic [15:0]           frame_d;

    assign scan_wrap  = (scan_q == SCAN_LAST);
    assign frame_wrap = scan_wrap && (digit_q == DIG_LAST);

    always_comb begin
        nib      = '0;
        dp_on    = 1'b0;
        upper_nz = 1'b0;
        sel_on   = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (digit_q == DW'(i)) begin
                nib       = data_q[4*i +: 4];
                dp_on     = dp_q[i];
                sel_on[i] = 1'b1;
            end
            if ((DW'(i) >= digit_q) && (data_q[4*i +: 4] != 4'h0))
                upper_nz = 1'b1;
        end
        blank = blz_q && (digit_q != '0) && !upper_nz;

        case (nib)
            4'h0: seg_on = 7'h3F;
            4'h1: seg_on = 7'h06;
            4'h2: seg_on = 7'h5B;
            4'h3: seg_on = 7'h4F;
            4'h4: seg_on = 7'h66;
            4'h5: seg_on = 7'h6D;
            4'h6: seg_on = 7'h7D;
            4'h7: seg_on = 7'h07;
            4'h8: seg_on = 7'h7F;
            4'h9: seg_on = 7'h6F;
            4'hA: seg_on = 7'h77;
            4'hB: seg_on = 7'h7C;
            4'hC: seg_on = 7'h39;
            4'hD: seg_on = 7'h5E;
            4'hE: seg_on = 7'h79;
            default: seg_on = 7'h71;
        endcase
        if (blank)
            seg_on = '0;

        if (!disp_en) begin
            seg_on = '0;
            dp_on  = 1'b0;
            sel_on = '0;
        end

        frame_d = {dp_on ^ SEG_ACTIVE_LOW,
                   seg_on ^ {7{SEG_ACTIVE_LOW}},
                   sel_on ^ {8{SEL_ACTIVE_LOW}}};
    end

    // Pending load is only committed at the digit-(DIGITS-1) -> 0 wrap so a scan round never mixes old and new data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_q  <= '0;
            digit_q <= '0;
            data_q  <= '0;
            dp_q    <= '0;
            blz_q   <= 1'b0;
            pdata_q <= '0;
            pdp_q   <= '0;
            pblz_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            scan_q <= scan_wrap ? '0 : scan_q + 1'b1;
            if (scan_wrap)
                digit_q <= (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;

            if (ready_q && load_valid) begin
                pdata_q <= data_in;
                pdp_q   <= dp_in;
                pblz_q  <= blank_lz;
                ready_q <= 1'b0;
            end else if (!ready_q && frame_wrap) begin
                data_q  <= pdata_q;
                dp_q    <= pdp_q;
                blz_q   <= pblz_q;
                ready_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            ds_q    <= 1'b0;
            sh_q    <= 1'b0;
            st_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            fd_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ds_q <= 1'b0;
                    sh_q <= 1'b0;
                    st_q <= 1'b0;
                    if (scan_q == '0) begin
                        state_q <= S_SHIFT;
                        sreg_q  <= frame_d;
                        ds_q    <= frame_d[15];
                        div_q   <= '0;
                        bit_q   <= '0;
                    end
                end
                S_SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (!sh_q) begin
                            sh_q <= 1'b1;
                        end else begin
                            sh_q <= 1'b0;
                            if (bit_q == 4'd15) begin
                                state_q <= S_LATCH;
                                st_q    <= 1'b1;
                                ds_q    <= 1'b0;
                            end else begin
                                bit_q  <= bit_q + 1'b1;
                                sreg_q <= {sreg_q[14:0], 1'b0};
                                ds_q   <= sreg_q[14];
                            end
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                S_LATCH: begin
                    if (div_q == DIV_LAST) begin
                        div_q   <= '0;
                        st_q    <= 1'b0;
                        state_q <= S_IDLE;
                        fd_q    <= (digit_q == DIG_LAST);
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign load_ready = ready_q;
    assign ds         = ds_q;
    assign sh_cp      = sh_q;
    assign st_cp      = st_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_hex_scan_595.sv
// Self-checking bench for hex_scan_595: decodes the serial stream back into frames
// and compares them with a spec-level display model.
module tb_hex_scan_595;

    localparam int unsigned DIGITS = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        disp_en;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic        blank_lz;
    logic        load_valid;
    logic        load_ready, ds, sh_cp, st_cp, frame_done;

    hex_scan_595 #(
        .DIGITS(8), .SHIFT_DIV(2), .SCAN_CYCLES(100),
        .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .disp_en(disp_en), .data_in(data_in),
        .dp_in(dp_in), .blank_lz(blank_lz), .load_valid(load_valid),
        .load_ready(load_ready), .ds(ds), .sh_cp(sh_cp), .st_cp(st_cp),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    localparam logic [6:0] SEG_TAB [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // What the digit should look like on the wire, from the display's point of view.
    function automatic logic [15:0] ref_frame(input logic [31:0] d, input logic [7:0] dp,
                                              input logic blz, input logic en, input int dig);
        logic [31:0] upper;
        logic [6:0]  seg;
        logic [7:0]  sel;
        logic        dpl;
        upper = d >> (4 * dig);
        seg   = SEG_TAB[upper & 32'hF];
        if (blz && dig > 0 && upper == 0) seg = 7'h00;
        dpl = dp[dig];
        sel = 8'(1 << dig);
        if (!en) begin
            seg = 7'h00; dpl = 1'b0; sel = 8'h00;
        end
        return ~{dpl, seg, sel};
    endfunction

    logic [31:0] m_data;
    logic [7:0]  m_dp;
    logic        m_blz, m_en;

    typedef struct {
        int          digit;
        logic [15:0] frame;
    } frm_t;
    frm_t fq[$];

    logic [15:0] acc;
    int          nbits, fidx, last_dig;
    logic        prev_sh, prev_st;

    always @(negedge clk) begin
        if (!reset_n) begin
            acc = '0; nbits = 0; fidx = 0; last_dig = -1;
            prev_sh = 1'b0; prev_st = 1'b0;
        end else begin
            if (sh_cp && !prev_sh) begin
                acc = {acc[14:0], ds};
                nbits++;
            end
            if (st_cp && !prev_st) begin
                chk("bits_per_frame", nbits, 16);
                fq.push_back('{digit: fidx % DIGITS, frame: acc});
                last_dig = fidx % DIGITS;
                fidx++;
                nbits = 0;
            end
            if (!st_cp && prev_st)
                chk("frame_done_at_latch", frame_done, (last_dig == DIGITS - 1) ? 1 : 0);
            else if (frame_done)
                chk("frame_done_spurious", frame_done, 0);
            prev_sh = sh_cp;
            prev_st = st_cp;
        end
    end

    task automatic wait_frames(input int n, input string name);
        for (int t = 0; t < 3000; t++) begin
            if (fq.size() >= n) return;
            @(negedge clk);
        end
        timeout(name);
    endtask

    task automatic wait_ready(input string name);
        for (int t = 0; t < 3000; t++) begin
            if (load_ready) return;
            @(negedge clk);
        end
        timeout(name);
    endtask

    task automatic wait_fd(input string name);
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (frame_done) return;
        end
        timeout(name);
    endtask

    task automatic check_round(input string tag);
        if (fq.size() >= DIGITS) begin
            for (int k = 0; k < DIGITS; k++) begin
                chk($sformatf("%s_digit_idx%0d", tag, k), fq[k].digit, k);
                chk($sformatf("%s_frame_d%0d", tag, k), fq[k].frame,
                    ref_frame(m_data, m_dp, m_blz, m_en, k));
            end
        end
    endtask

    // Load new contents, wait for them to be committed, then capture one full scan round.
    task automatic show(input logic [31:0] d, input logic [7:0] dp, input logic blz, input logic en);
        disp_en = en;
        @(negedge clk);
        wait_ready("ready_before_load");
        data_in = d; dp_in = dp; blank_lz = blz; load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        chk("ready_drop", load_ready, 0);
        wait_ready("ready_return");
        fq.delete();
        m_data = d; m_dp = dp; m_blz = blz; m_en = en;
        wait_frames(DIGITS, "round_frames");
    endtask

    typedef struct {
        logic [31:0] d;
        logic [7:0]  dp;
        logic        blz;
        logic        en;
        int          da;
        logic [15:0] ea;
        int          db;
        logic [15:0] eb;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int first_hi, hi_cnt, c0, cnt;
        logic [31:0] old_d, new_d;
        logic [7:0]  old_dp;
        logic        old_blz;

        tbl[0] = '{32'h12345678, 8'h01, 1'b0, 1'b1, 0, 16'h00FE, 7, 16'hF97F};
        tbl[1] = '{32'h000000A0, 8'h00, 1'b1, 1'b1, 1, 16'h88FD, 7, 16'hFF7F};
        tbl[2] = '{32'hDEADBEEF, 8'hFF, 1'b0, 1'b0, 0, 16'hFFFF, 5, 16'hFFFF};
        tbl[3] = '{32'h00000000, 8'h80, 1'b1, 1'b1, 7, 16'h7F7F, 0, 16'hC0FE};
        tbl[4] = '{32'h0F000000, 8'h00, 1'b1, 1'b1, 7, 16'hFF7F, 6, 16'h8EBF};
        tbl[5] = '{32'h00000000, 8'h00, 1'b0, 1'b1, 3, 16'hC0F7, 5, 16'hC0DF};

        reset_n = 1'b0; disp_en = 1'b1; data_in = '0; dp_in = '0;
        blank_lz = 1'b0; load_valid = 1'b0;
        m_data = '0; m_dp = '0; m_blz = 1'b0; m_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ds", ds, 0);
        chk("rst_sh_cp", sh_cp, 0);
        chk("rst_st_cp", st_cp, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_load_ready", load_ready, 1);

        // First frame right after release: latch window timing and content.
        fq.delete();
        reset_n = 1'b1;
        c0 = cyc; first_hi = -1; hi_cnt = 0;
        for (int t = 0; t < 120; t++) begin
            @(negedge clk);
            if (st_cp) begin
                if (first_hi < 0) first_hi = cyc - c0;
                hi_cnt++;
            end
        end
        chk("first_st_rise_cycle", first_hi, 65);
        chk("first_st_high_len", hi_cnt, 2);
        wait_frames(1, "first_frame");
        if (fq.size() >= 1) chk("first_frame", fq[0].frame, 16'hC0FE);
        wait_frames(DIGITS, "reset_round");
        check_round("reset");

        for (int v = 0; v < 6; v++) begin
            show(tbl[v].d, tbl[v].dp, tbl[v].blz, tbl[v].en);
            if (fq.size() >= DIGITS) begin
                chk($sformatf("vec%0d_d%0d", v, tbl[v].da), fq[tbl[v].da].frame, tbl[v].ea);
                chk($sformatf("vec%0d_d%0d", v, tbl[v].db), fq[tbl[v].db].frame, tbl[v].eb);
            end
            check_round($sformatf("vec%0d", v));
        end

        // Load accepted mid-round (digit 3) stays pending until the round wraps.
        old_d = 32'h87654321; old_dp = 8'h5A; old_blz = 1'b0;
        show(old_d, old_dp, old_blz, 1'b1);
        wait_fd("window_sync");
        repeat (343) @(negedge clk);
        new_d = 32'h00C0FFEE;
        data_in = new_d; dp_in = 8'h81; blank_lz = 1'b1; load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        chk("window_ready_drop", load_ready, 0);
        fq.delete();
        cnt = 1;
        for (int t = 0; t < 2000; t++) begin
            if (cnt == 50) begin
                data_in = 32'hFFFFFFFF; dp_in = 8'hFF; blank_lz = 1'b0; load_valid = 1'b1;
            end else begin
                load_valid = 1'b0;
            end
            @(negedge clk);
            if (load_ready) break;
            cnt++;
        end
        load_valid = 1'b0;
        chk("window_ready_low_cycles", cnt, 489);
        chk("window_old_frames", fq.size(), 5);
        foreach (fq[k])
            chk($sformatf("window_old_d%0d", fq[k].digit), fq[k].frame,
                ref_frame(old_d, old_dp, old_blz, 1'b1, fq[k].digit));
        fq.delete();
        m_data = new_d; m_dp = 8'h81; m_blz = 1'b1; m_en = 1'b1;
        wait_frames(DIGITS, "window_new_round");
        check_round("window_new");

        disp_en = 1'b0;
        wait_fd("fd_a");
        c0 = cyc;
        wait_fd("fd_b");
        chk("frame_done_period", cyc - c0, 800);
        disp_en = 1'b1;

        repeat (6) begin
            logic [31:0] rd;
            rd = $urandom >> (4 * $urandom_range(0, 8));
            show(rd, 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0));
            check_round("rand");
        end

        // Reset in the middle of a shift: pins drop at once and the partial frame is abandoned.
        show(32'h9ABCDEF1, 8'hAA, 1'b0, 1'b1);
        cnt = 0;
        for (int t = 0; t < 2000; t++) begin
            if (nbits == 7) break;
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 2000) timeout("mid_reset_sync");
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_ds", ds, 0);
        chk("midrst_sh_cp", sh_cp, 0);
        chk("midrst_st_cp", st_cp, 0);
        chk("midrst_load_ready", load_ready, 1);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_st_hold", st_cp, 0);
        end
        fq.delete();
        m_data = '0; m_dp = '0; m_blz = 1'b0; m_en = 1'b1;
        reset_n = 1'b1;
        wait_frames(1, "midrst_first");
        if (fq.size() >= 1) begin
            chk("midrst_first_digit", fq[0].digit, 0);
            chk("midrst_first_frame", fq[0].frame, 16'hC0FE);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
